// File: rtl/vs_dp4_sequencer_pkg.sv
// Types and constants shared by the DP4 sequencer, its watchdog and its bench.
`include "vs_defines.vh"

package vs_dp4_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE      = `VS_SEQ_IDLE,
        SEQ_MUL_ISSUE = `VS_SEQ_MUL_ISSUE,
        SEQ_MUL_WAIT  = `VS_SEQ_MUL_WAIT,
        SEQ_ACC_ISSUE = `VS_SEQ_ACC_ISSUE,
        SEQ_ACC_WAIT  = `VS_SEQ_ACC_WAIT,
        SEQ_DONE      = `VS_SEQ_DONE
    } seqState_t;

    localparam int VS_DATA_WIDTH = `SHADER_ALU_DATA_WIDTH;
    localparam int VS_OP_WIDTH   = `SHADER_ALU_OP_WIDTH;
    localparam int VS_TIMEOUT    = 64;
    localparam int VS_LANES      = 4;

    localparam logic [VS_OP_WIDTH-1:0] VS_OP_DP4 = `OP_DP4;

endpackage

// File: rtl/vs_defines.vh
// Shared vertex-shader ALU widths, the DP4 opcode and the DP4 sequencer state encodings.
`ifndef VS_DEFINES_VH
`define VS_DEFINES_VH

`define SHADER_ALU_DATA_WIDTH 32
`define SHADER_ALU_OP_WIDTH   6
`define OP_DP4                6'h2C

`define VS_SEQ_IDLE      3'd0
`define VS_SEQ_MUL_ISSUE 3'd1
`define VS_SEQ_MUL_WAIT  3'd2
`define VS_SEQ_ACC_ISSUE 3'd3
`define VS_SEQ_ACC_WAIT  3'd4
`define VS_SEQ_DONE      3'd5

`endif

// File: rtl/vs_seq_watchdog.sv
// Per-phase wait counter: expire is raised in the TIMEOUT-th consecutive enabled cycle.
module vs_seq_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Saturates at TIMEOUT so a stalled caller cannot wrap back into a quiet window.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != CW'(TIMEOUT))) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/vs_dp4_sequencer.sv
// Runs one DP4 as four ALU multiplies followed by one four-input accumulate, with a wait watchdog.
module vs_dp4_sequencer
    import vs_dp4_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = VS_DATA_WIDTH,
    parameter int OP_WIDTH   = VS_OP_WIDTH,
    parameter int TIMEOUT    = VS_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           iReqValid,
    output logic                           oReqReady,
    input  logic [VS_LANES*DATA_WIDTH-1:0] iVecA,
    input  logic [VS_LANES*DATA_WIDTH-1:0] iVecB,
    output logic                           oAluValid,
    output logic [DATA_WIDTH-1:0]          oAluA,
    output logic [DATA_WIDTH-1:0]          oAluB,
    output logic [OP_WIDTH-1:0]            oAluOp,
    input  logic                           iAluReady,
    input  logic [DATA_WIDTH-1:0]          iAluResult,
    output logic                           oAccValid,
    output logic [DATA_WIDTH-1:0]          oAccX,
    output logic [DATA_WIDTH-1:0]          oAccY,
    output logic [DATA_WIDTH-1:0]          oAccZ,
    output logic [DATA_WIDTH-1:0]          oAccW,
    input  logic                           iAccReady,
    input  logic [DATA_WIDTH-1:0]          iAccResult,
    output logic                           oDone,
    output logic [DATA_WIDTH-1:0]          oResult,
    output logic                           oZero,
    output logic                           oError
);

    seqState_t state, stateNext;

    logic [1:0]                     idx, idxNext;
    logic [VS_LANES*DATA_WIDTH-1:0] vecA, vecB;
    logic [DATA_WIDTH-1:0]          prod     [VS_LANES];
    logic [DATA_WIDTH-1:0]          prodNext [VS_LANES];
    logic [DATA_WIDTH-1:0]          issueA, issueB;
    logic                           latchReq, captureProd, latchResult, raiseError;
    logic                           wdClear, wdEnable, wdExpire;

    vs_seq_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) uWatchdog (
        .clk   (clk),
        .reset (reset),
        .clear (wdClear),
        .enable(wdEnable),
        .expire(wdExpire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEQ_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A ready strobe beats a same-cycle watchdog expiry; strobes in other states are ignored.
    always_comb begin
        stateNext   = state;
        idxNext     = idx;
        latchReq    = 1'b0;
        captureProd = 1'b0;
        latchResult = 1'b0;
        raiseError  = 1'b0;
        wdClear     = 1'b0;
        wdEnable    = 1'b0;
        unique case (state)
            SEQ_IDLE: begin
                if (iReqValid && oReqReady) begin
                    latchReq  = 1'b1;
                    idxNext   = 2'd0;
                    stateNext = SEQ_MUL_ISSUE;
                end
            end
            SEQ_MUL_ISSUE: begin
                wdClear   = 1'b1;
                stateNext = SEQ_MUL_WAIT;
            end
            SEQ_MUL_WAIT: begin
                wdEnable = 1'b1;
                if (iAluReady) begin
                    captureProd = 1'b1;
                    if (idx == 2'd3) begin
                        stateNext = SEQ_ACC_ISSUE;
                    end else begin
                        idxNext   = idx + 2'd1;
                        stateNext = SEQ_MUL_ISSUE;
                    end
                end else if (wdExpire) begin
                    raiseError = 1'b1;
                    stateNext  = SEQ_IDLE;
                end
            end
            SEQ_ACC_ISSUE: begin
                wdClear   = 1'b1;
                stateNext = SEQ_ACC_WAIT;
            end
            SEQ_ACC_WAIT: begin
                wdEnable = 1'b1;
                if (iAccReady) begin
                    latchResult = 1'b1;
                    stateNext   = SEQ_DONE;
                end else if (wdExpire) begin
                    raiseError = 1'b1;
                    stateNext  = SEQ_IDLE;
                end
            end
            SEQ_DONE: begin
                stateNext = SEQ_IDLE;
            end
            default: begin
                stateNext = SEQ_IDLE;
            end
        endcase
    end

    // The first operand pair comes straight from the request since vecA/vecB load on the same edge.
    always_comb begin
        prodNext = prod;
        if (captureProd) begin
            prodNext[idx] = iAluResult;
        end
        if (latchReq) begin
            issueA = iVecA[DATA_WIDTH-1:0];
            issueB = iVecB[DATA_WIDTH-1:0];
        end else begin
            issueA = vecA[int'(idxNext)*DATA_WIDTH +: DATA_WIDTH];
            issueB = vecB[int'(idxNext)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Outputs are registered from the next state so each pulse lines up with its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx  <= '0;
            vecA <= '0;
            vecB <= '0;
            for (int i = 0; i < VS_LANES; i++) begin
                prod[i] <= '0;
            end
            oReqReady <= 1'b1;
            oAluValid <= 1'b0;
            oAluA     <= '0;
            oAluB     <= '0;
            oAluOp    <= '0;
            oAccValid <= 1'b0;
            oAccX     <= '0;
            oAccY     <= '0;
            oAccZ     <= '0;
            oAccW     <= '0;
            oDone     <= 1'b0;
            oResult   <= '0;
            oZero     <= 1'b0;
            oError    <= 1'b0;
        end else begin
            idx <= idxNext;
            if (latchReq) begin
                vecA <= iVecA;
                vecB <= iVecB;
            end
            for (int i = 0; i < VS_LANES; i++) begin
                prod[i] <= (raiseError || latchReq) ? '0 : prodNext[i];
            end
            oReqReady <= (stateNext == SEQ_IDLE);
            oAluValid <= (stateNext == SEQ_MUL_ISSUE);
            oAluOp    <= (stateNext == SEQ_MUL_ISSUE) ? OP_WIDTH'(VS_OP_DP4) : '0;
            if (stateNext == SEQ_MUL_ISSUE) begin
                oAluA <= issueA;
                oAluB <= issueB;
            end
            oAccValid <= (stateNext == SEQ_ACC_ISSUE);
            if (stateNext == SEQ_ACC_ISSUE) begin
                oAccX <= prodNext[0];
                oAccY <= prodNext[1];
                oAccZ <= prodNext[2];
                oAccW <= prodNext[3];
            end
            oDone <= (stateNext == SEQ_DONE);
            if (latchResult) begin
                oResult <= iAccResult;
                oZero   <= (iAccResult == '0);
            end
            oError <= raiseError;
        end
    end

endmodule

// File: tb/tb_vs_dp4_sequencer.sv
// Scoreboard bench for vs_dp4_sequencer with latency-programmable ALU and accumulator models.
module tb_vs_dp4_sequencer;
    import vs_dp4_sequencer_pkg::*;

    localparam int DW  = VS_DATA_WIDTH;
    localparam int OPW = VS_OP_WIDTH;
    localparam int TMO = VS_TIMEOUT;

    typedef struct packed {
        bit            isError;
        logic [DW-1:0] result;
        int            latency;
    } expResult_t;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } expPair_t;

    typedef logic [3:0][DW-1:0] prodVec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          iReqValid;
    logic          oReqReady;
    logic [4*DW-1:0] iVecA, iVecB;
    logic          oAluValid;
    logic [DW-1:0] oAluA, oAluB;
    logic [OPW-1:0] oAluOp;
    logic          iAluReady;
    logic [DW-1:0] iAluResult;
    logic          oAccValid;
    logic [DW-1:0] oAccX, oAccY, oAccZ, oAccW;
    logic          iAccReady;
    logic [DW-1:0] iAccResult;
    logic          oDone;
    logic [DW-1:0] oResult;
    logic          oZero;
    logic          oError;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int acceptCyc = 0;
    int acceptCount = 0;
    int doneCount = 0;
    int lm = 3;
    int la = 2;
    bit aluMute = 1'b0;
    bit strayAlu = 1'b0;

    expResult_t resQ[$];
    expPair_t   pairQ[$];
    prodVec_t   prodQ[$];

    vs_dp4_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .iReqValid (iReqValid),
        .oReqReady (oReqReady),
        .iVecA     (iVecA),
        .iVecB     (iVecB),
        .oAluValid (oAluValid),
        .oAluA     (oAluA),
        .oAluB     (oAluB),
        .oAluOp    (oAluOp),
        .iAluReady (iAluReady),
        .iAluResult(iAluResult),
        .oAccValid (oAccValid),
        .oAccX     (oAccX),
        .oAccY     (oAccY),
        .oAccZ     (oAccZ),
        .oAccW     (oAccW),
        .iAccReady (iAccReady),
        .iAccResult(iAccResult),
        .oDone     (oDone),
        .oResult   (oResult),
        .oZero     (oZero),
        .oError    (oError)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ALU model: answers each issue lm cycles later with the truncated product.
    initial begin : aluModel
        int cnt;
        bit pending;
        logic [DW-1:0] held;
        iAluReady  = 1'b0;
        iAluResult = '0;
        pending    = 1'b0;
        cnt        = 0;
        held       = '0;
        forever begin
            tick();
            iAluReady = 1'b0;
            if (strayAlu) begin
                iAluReady  = 1'b1;
                iAluResult = 32'hDEAD_BEEF;
                strayAlu   = 1'b0;
            end else if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    iAluReady  = 1'b1;
                    iAluResult = held;
                    pending    = 1'b0;
                end
            end else if (oAluValid && !aluMute) begin
                pending = 1'b1;
                cnt     = lm;
                held    = oAluA * oAluB;
            end
        end
    end

    // Accumulator model: answers each issue la cycles later with the wrapped sum.
    initial begin : accModel
        int cnt;
        bit pending;
        logic [DW-1:0] held;
        iAccReady  = 1'b0;
        iAccResult = '0;
        pending    = 1'b0;
        cnt        = 0;
        held       = '0;
        forever begin
            tick();
            iAccReady = 1'b0;
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    iAccReady  = 1'b1;
                    iAccResult = held;
                    pending    = 1'b0;
                end
            end else if (oAccValid) begin
                pending = 1'b1;
                cnt     = la;
                held    = oAccX + oAccY + oAccZ + oAccW;
            end
        end
    end

    // Monitor: pops the scoreboard on every DUT issue/completion and tracks the request handshake.
    initial begin : monitor
        bit busy;
        bit doneLast;
        expPair_t p;
        prodVec_t pv;
        expResult_t e;
        busy     = 1'b0;
        doneLast = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                busy     = 1'b0;
                doneLast = 1'b0;
            end else begin
                if (doneLast) checkOutput("readyAfterDone", 128'(oReqReady), 128'(1));
                doneLast = 1'b0;
                checkOutput("aluOp", 128'(oAluOp), oAluValid ? 128'(VS_OP_DP4) : 128'(0));
                if (oError) begin
                    checkOutput("errorQueued", 128'(resQ.size() != 0), 128'(1));
                    if (resQ.size() != 0) begin
                        e = resQ.pop_front();
                        checkOutput("errorExpected", 128'(e.isError), 128'(1));
                        checkOutput("errorLatency", 128'(cyc - acceptCyc), 128'(e.latency));
                    end
                    busy = 1'b0;
                end
                if (busy) checkOutput("readyWhileBusy", 128'(oReqReady), 128'(0));
                if (oAluValid) begin
                    checkOutput("aluQueued", 128'(pairQ.size() != 0), 128'(1));
                    if (pairQ.size() != 0) begin
                        p = pairQ.pop_front();
                        checkOutput("aluA", 128'(oAluA), 128'(p.a));
                        checkOutput("aluB", 128'(oAluB), 128'(p.b));
                    end
                end
                if (oAccValid) begin
                    checkOutput("accQueued", 128'(prodQ.size() != 0), 128'(1));
                    if (prodQ.size() != 0) begin
                        pv = prodQ.pop_front();
                        checkOutput("accXYZW", {oAccW, oAccZ, oAccY, oAccX}, 128'(pv));
                    end
                end
                if (oDone) begin
                    doneCount++;
                    checkOutput("doneQueued", 128'(resQ.size() != 0), 128'(1));
                    if (resQ.size() != 0) begin
                        e = resQ.pop_front();
                        checkOutput("doneNotError", 128'(e.isError), 128'(0));
                        checkOutput("result", 128'(oResult), 128'(e.result));
                        checkOutput("zero", 128'(oZero), 128'(e.result == '0));
                        checkOutput("doneLatency", 128'(cyc - acceptCyc), 128'(e.latency));
                    end
                    busy     = 1'b0;
                    doneLast = 1'b1;
                end
                if (iReqValid && oReqReady) begin
                    busy      = 1'b1;
                    acceptCyc = cyc;
                    acceptCount++;
                end
            end
        end
    end

    // Presents a request (valid is left high) and returns just after the accept edge.
    task automatic applyStimulus(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b);
        expResult_t e;
        prodVec_t pv;
        logic [DW-1:0] sum;
        logic [DW-1:0] pa, pb;
        bit ok;
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            pa    = a[i*DW +: DW];
            pb    = b[i*DW +: DW];
            pv[i] = pa * pb;
            sum   = sum + pv[i];
            if (!aluMute || i == 0) pairQ.push_back('{a: pa, b: pb});
        end
        e.isError = aluMute;
        e.result  = sum;
        e.latency = aluMute ? (2 + TMO) : (4 * (1 + lm) + (1 + la) + 1);
        if (!aluMute) prodQ.push_back(pv);
        resQ.push_back(e);
        iVecA     = a;
        iVecB     = b;
        iReqValid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (oReqReady && !reset) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("accepted", 128'(ok), 128'(1));
        tick();
    endtask

    task automatic waitDrain(input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (resQ.size() == 0) break;
        end
        checkOutput("drained", 128'(resQ.size()), 128'(0));
        tick();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Ctl"}, 128'({oReqReady, oAluValid, oAccValid, oDone, oZero, oError}), 128'(6'b100000));
        checkOutput({tag, "Data"}, 128'({oAluOp, oAluA, oAluB, oResult}), 128'(0));
        checkOutput({tag, "Acc"}, {oAccX, oAccY, oAccZ, oAccW}, 128'(0));
    endtask

    initial begin : globalTimeout
        #500000;
        $display("[TB] FAIL globalTimeout cycles=%0d limit=50000", cyc);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : main
        int acc0, done0;
        reset     = 1'b1;
        iReqValid = 1'b0;
        iVecA     = '0;
        iVecB     = '0;
        repeat (3) tick();
        checkResetState("resetInit");
        reset = 1'b0;

        $display("[TB] basic dot product, Lm=9 La=13");
        lm = 9;
        la = 13;
        applyStimulus({32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5});
        iReqValid = 1'b0;
        waitDrain(400);

        $display("[TB] zero result");
        lm = 3;
        la = 2;
        applyStimulus('0, {32'd7, 32'd7, 32'd7, 32'd7});
        iReqValid = 1'b0;
        waitDrain(200);

        $display("[TB] ALU watchdog abort");
        aluMute = 1'b1;
        applyStimulus({32'd1, 32'd1, 32'd1, 32'd9}, {32'd1, 32'd1, 32'd1, 32'd9});
        iReqValid = 1'b0;
        waitDrain(200);
        aluMute  = 1'b0;
        strayAlu = 1'b1;
        repeat (4) tick();
        checkOutput("strayIgnored", 128'({oReqReady, oAluValid, oAccValid, oDone, oError}), 128'(5'b10000));
        applyStimulus({32'd10, 32'd20, 32'd30, 32'd40}, {32'd2, 32'd3, 32'd4, 32'd5});
        iReqValid = 1'b0;
        waitDrain(200);

        $display("[TB] wrap-around");
        applyStimulus({32'hFFFF_FFFF, 32'h8000_0001, 32'h0001_0000, 32'h0001_0000},
                      {32'd1, 32'd2, 32'h0001_0000, 32'h0001_0000});
        iReqValid = 1'b0;
        waitDrain(200);

        $display("[TB] back-to-back");
        acc0  = acceptCount;
        done0 = doneCount;
        applyStimulus({32'd1, 32'd2, 32'd3, 32'd4}, {32'd1, 32'd1, 32'd1, 32'd1});
        applyStimulus({32'd5, 32'd6, 32'd7, 32'd8}, {32'd2, 32'd2, 32'd2, 32'd2});
        iReqValid = 1'b0;
        waitDrain(400);
        checkOutput("b2bAccepts", 128'(acceptCount - acc0), 128'(2));
        checkOutput("b2bDones", 128'(doneCount - done0), 128'(2));

        $display("[TB] reset during accumulator wait");
        lm = 2;
        la = 30;
        applyStimulus({32'd3, 32'd3, 32'd3, 32'd3}, {32'd3, 32'd3, 32'd3, 32'd3});
        iReqValid = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (oAccValid) break;
        end
        checkOutput("reachedAcc", 128'(oAccValid), 128'(1));
        tick();
        repeat (3) tick();
        reset = 1'b1;
        resQ.delete();
        pairQ.delete();
        prodQ.delete();
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkResetState("midReset");
        repeat (40) tick();
        checkOutput("lateAccIgnored", 128'({oReqReady, oDone, oError}), 128'(3'b100));
        la = 2;
        applyStimulus({32'd9, 32'd8, 32'd7, 32'd6}, {32'd1, 32'd2, 32'd3, 32'd4});
        iReqValid = 1'b0;
        waitDrain(200);

        repeat (3) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
